// File: rtl/rsa_pkg.sv
// ============================================================================
// Module : rsa_pkg
// Brief  : Shared constants and helpers for the RSA modular arithmetic units.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rsa_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // Bit-index counter width; clamped so a degenerate width still yields a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/modmul_step.sv
// ============================================================================
// Module : modmul_step
// Brief  : One MSB-first interleaved step: r_next = (2r + bit*b) mod n, given r,b < n.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module modmul_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  input  logic             a_bit,
  output logic [WIDTH-1:0] r_next
);

  logic [WIDTH+1:0] w_n_ext;
  logic [WIDTH+1:0] w_t;
  logic [WIDTH+1:0] w_u;

  assign w_n_ext = {2'b00, n};
  // t < 3n, so two conditional subtractions always land back in [0, n).
  assign w_t     = {1'b0, r, 1'b0} + (a_bit ? {2'b00, b} : '0);
  assign w_u     = (w_t >= w_n_ext) ? (w_t - w_n_ext) : w_t;
  assign r_next  = (w_u >= w_n_ext) ? WIDTH'(w_u - w_n_ext) : WIDTH'(w_u);

endmodule

`default_nettype wire

// File: rtl/modmul_serial.sv
// ============================================================================
// Module : modmul_serial
// Brief  : Bit-serial (a*b) mod n with start/busy/done handshake and operand check.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module modmul_serial
  import rsa_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_idx;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_err;

  logic [WIDTH-1:0] w_r_next;
  logic             w_operand_err;

  assign w_operand_err = (r_n == '0) || (r_a >= r_n) || (r_b >= r_n);

  modmul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r      (r_acc),
    .b      (r_b),
    .n      (r_n),
    .a_bit  (r_a[r_idx]),
    .r_next (w_r_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_n      <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_n     <= n;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_operand_err) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_idx   <= CNT_W'(WIDTH - 1);
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc <= w_r_next;
          if (r_idx == '0) begin
            r_result <= w_r_next;
            r_err    <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_modmul_serial.sv
// ============================================================================
// Module : tb_modmul_serial
// Brief  : Self-checking bench for modmul_serial at WIDTH 8, 16 and 64.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_modmul_serial;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_v [NI];
  logic [63:0] a_v     [NI];
  logic [63:0] b_v     [NI];
  logic [63:0] n_v     [NI];
  logic        busy_v  [NI];
  logic        done_v  [NI];
  logic        err_v   [NI];
  logic [63:0] res_v   [NI];
  logic [7:0]  res8;
  logic [15:0] res16;
  logic [63:0] res64;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  modmul_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .n(n_v[0][7:0]),
    .busy(busy_v[0]), .done(done_v[0]), .result(res8), .err(err_v[0]));

  modmul_serial #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .a(a_v[1][15:0]), .b(b_v[1][15:0]), .n(n_v[1][15:0]),
    .busy(busy_v[1]), .done(done_v[1]), .result(res16), .err(err_v[1]));

  modmul_serial #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .a(a_v[2]), .b(b_v[2]), .n(n_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .result(res64), .err(err_v[2]));

  assign res_v[0] = {56'd0, res8};
  assign res_v[1] = {48'd0, res16};
  assign res_v[2] = res64;

  function automatic int width_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 16 : 64;
  endfunction

  function automatic logic [63:0] ref_mod(input logic [63:0] a, b, n);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return 64'(p % {64'd0, n});
  endfunction

  // Transaction-level model: an accepted start schedules done a fixed number of edges later.
  logic        m_busy [NI];
  logic        m_done [NI];
  logic        m_err  [NI];
  logic [63:0] m_res  [NI];
  logic [63:0] p_res  [NI];
  logic        p_err  [NI];
  int          m_cnt  [NI];

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_busy[k] = 1'b0; m_done[k] = 1'b0; m_err[k] = 1'b0;
        m_res[k] = '0;    m_cnt[k] = 0;
      end else begin
        m_done[k] = 1'b0;
        if (m_busy[k]) begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) begin
            m_done[k] = 1'b1; m_busy[k] = 1'b0;
            m_res[k] = p_res[k]; m_err[k] = p_err[k];
          end
        end else if (start_v[k]) begin
          p_err[k] = (n_v[k] == 0) || (a_v[k] >= n_v[k]) || (b_v[k] >= n_v[k]);
          p_res[k] = p_err[k] ? 64'd0 : ref_mod(a_v[k], b_v[k], n_v[k]);
          m_cnt[k] = p_err[k] ? 1 : width_of(k) + 1;
          m_busy[k] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (w%0d) cyc=%0d: got %0h expected %0h", nm, width_of(k), cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        chk("busy", k, 64'(busy_v[k]), 64'(m_busy[k]));
        chk("done", k, 64'(done_v[k]), 64'(m_done[k]));
        chk("result", k, res_v[k], m_res[k]);
        chk("err", k, 64'(err_v[k]), 64'(m_err[k]));
      end
    end
  end

  // Presents operands at a negedge; returns just after E0 with start released.
  task automatic launch(input int k, input logic [63:0] a, b, n);
    @(negedge clk);
    start_v[k] = 1'b1; a_v[k] = a; b_v[k] = b; n_v[k] = n;
    @(posedge clk);
    #1 start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int bound, output int lat);
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done_v[k]) return;
      if (lat >= bound) begin
        n_vec++; n_err++;
        $display("FAIL done_timeout (w%0d): no done within %0d cycles", width_of(k), bound);
        return;
      end
    end
  endtask

  task automatic op(input string nm, input int k, input logic [63:0] a, b, n,
                    input logic [63:0] exp_res, input logic exp_err, input int exp_lat);
    int lat;
    launch(k, a, b, n);
    wait_done(k, 100, lat);
    chk({nm, " latency"}, k, 64'(lat), 64'(exp_lat));
    chk({nm, " result"}, k, res_v[k], exp_res);
    chk({nm, " err"}, k, 64'(err_v[k]), 64'(exp_err));
  endtask

  initial begin
    logic [63:0] nbig;
    logic [63:0] ra, rb, rn;
    int lat, t1, t2, dcount;
    for (int k = 0; k < NI; k++) begin
      start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; n_v[k] = '0;
    end
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset busy", 0, 64'(busy_v[0]), 64'd0);
    chk("reset result", 0, res_v[0], 64'd0);

    op("7x9%13", 0, 7, 9, 13, 11, 1'b0, 9);

    nbig = 64'hFFFF_FFFF_FFFF_FFC5;
    op("(n-1)^2%n", 2, nbig - 1, nbig - 1, nbig, 1, 1'b0, 65);
    op("2^63*2%n", 2, 64'h8000_0000_0000_0000, 2, nbig, 59, 1'b0, 65);

    op("n=0", 0, 1, 1, 0, 0, 1'b1, 1);
    op("a>=n", 0, 13, 5, 13, 0, 1'b1, 1);
    op("b>=n", 0, 1, 200, 100, 0, 1'b1, 1);

    // start raised at E3 with other operands must be ignored
    launch(0, 7, 9, 13);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 3; b_v[0] = 4; n_v[0] = 5;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    wait_done(0, 50, lat);
    chk("ignored start latency", 0, 64'(lat), 64'd6);
    chk("ignored start result", 0, res_v[0], 64'd11);

    // start held through the done cycle: second op begins immediately
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 7; b_v[0] = 9; n_v[0] = 13;
    @(posedge clk);
    #1 begin a_v[0] = 12; b_v[0] = 12; end
    wait_done(0, 50, lat);
    t1 = cyc;
    chk("b2b first result", 0, res_v[0], 64'd11);
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    wait_done(0, 50, lat);
    t2 = cyc;
    chk("b2b done spacing", 0, 64'(t2 - t1), 64'd10);
    chk("b2b second result", 0, res_v[0], 64'd1);

    // reset asserted for the E4 edge of a run
    launch(0, 7, 9, 13);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post-reset busy", 0, 64'(busy_v[0]), 64'd0);
    chk("post-reset done", 0, 64'(done_v[0]), 64'd0);
    chk("post-reset result", 0, res_v[0], 64'd0);
    chk("post-reset err", 0, 64'(err_v[0]), 64'd0);
    dcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_v[0]) dcount++;
    end
    chk("no done after reset", 0, 64'(dcount), 64'd0);
    op("12x12%13", 0, 12, 12, 13, 1, 1'b0, 9);

    op("n=1", 1, 0, 0, 1, 0, 1'b0, 17);

    for (int i = 0; i < 150; i++) begin
      rn = 64'($urandom_range(0, 65535));
      if ($urandom_range(0, 19) == 0) rn = 0;
      ra = (rn != 0) ? 64'($urandom_range(0, 65535)) % rn : 64'($urandom_range(0, 65535));
      rb = (rn != 0) ? 64'($urandom_range(0, 65535)) % rn : 64'($urandom_range(0, 65535));
      if ($urandom_range(0, 9) == 0) ra = 64'($urandom_range(0, 65535));
      launch(1, ra, rb, rn);
      if (rn != 0 && ra < rn && rb < rn && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        start_v[1] = 1'b1; a_v[1] = 64'($urandom_range(0, 65535)); n_v[1] = 64'd7;
        @(negedge clk);
        start_v[1] = 1'b0;
      end
      wait_done(1, 40, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
